// File: rtl/ballot_tx.sv
// ballot_tx: serial ballot transmitter.
// Frame = start bit (0), DATA_W data bits LSB first, optional even-parity bit, stop bit (1).
// Every bit lasts CLK_DIV clock cycles.
// Optional feature: define BALLOT_TX_PARITY_EN to compile in the parity state and bit.
module ballot_tx #(
   parameter int DATA_W  = 8,
   parameter int CLK_DIV = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] vote_data,
   input  logic              vote_valid,
   output logic              vote_ready,
   output logic              tx_line,
   output logic              busy,
   output logic [7:0]        sent_count
);

   localparam int                IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [7:0]        DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

`ifdef BALLOT_TX_PARITY_EN
   // Even parity over the whole ballot word.
   function automatic logic even_parity(input logic [DATA_W-1:0] d);
      logic p;
      p = 1'b0;
      for (int i = 0; i < DATA_W; i++) begin
         p = p ^ d[i];
      end
      return p;
   endfunction
`endif

   state_t             r_state;
   state_t             w_state_nxt;
   logic [7:0]         r_div;
   logic [7:0]         w_div_nxt;
   logic [IDX_W-1:0]   r_idx;
   logic [IDX_W-1:0]   w_idx_nxt;
   logic [DATA_W-1:0]  r_shift;
   logic [DATA_W-1:0]  w_shift_nxt;
   logic               r_tx;
   logic               w_tx_nxt;
   logic [7:0]         r_count;
   logic [7:0]         w_count_nxt;
`ifdef BALLOT_TX_PARITY_EN
   logic               r_par;
   logic               w_par_nxt;
`endif
   logic               w_accept;
   logic               w_bit_end;

   assign vote_ready = (r_state == S_IDLE) && !rst;
   assign busy       = (r_state != S_IDLE);
   assign tx_line    = r_tx;
   assign sent_count = r_count;
   assign w_accept   = vote_valid && vote_ready;
   assign w_bit_end  = (r_div == DIV_LAST);

   // State and datapath registers; reset aborts any frame and forces the line idle-high.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_div   <= 8'd0;
         r_idx   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
         r_count <= 8'd0;
`ifdef BALLOT_TX_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_div   <= w_div_nxt;
         r_idx   <= w_idx_nxt;
         r_shift <= w_shift_nxt;
         r_tx    <= w_tx_nxt;
         r_count <= w_count_nxt;
`ifdef BALLOT_TX_PARITY_EN
         r_par   <= w_par_nxt;
`endif
      end
   end

   // Next-state: advance one frame field at each bit boundary.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_nxt = S_START;
            else          w_state_nxt = S_IDLE;
         end
         S_START: begin
            if (w_bit_end) w_state_nxt = S_DATA;
            else           w_state_nxt = S_START;
         end
         S_DATA: begin
            if (w_bit_end && (r_idx == IDX_LAST)) begin
`ifdef BALLOT_TX_PARITY_EN
               w_state_nxt = S_PARITY;
`else
               w_state_nxt = S_STOP;
`endif
            end else begin
               w_state_nxt = S_DATA;
            end
         end
`ifdef BALLOT_TX_PARITY_EN
         S_PARITY: begin
            if (w_bit_end) w_state_nxt = S_STOP;
            else           w_state_nxt = S_PARITY;
         end
`endif
         S_STOP: begin
            if (w_bit_end) w_state_nxt = S_IDLE;
            else           w_state_nxt = S_STOP;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output/datapath next values: the line level is prepared one cycle ahead so tx_line is a flop.
   always_comb begin
      w_div_nxt   = r_div;
      w_idx_nxt   = r_idx;
      w_shift_nxt = r_shift;
      w_tx_nxt    = r_tx;
      w_count_nxt = r_count;
`ifdef BALLOT_TX_PARITY_EN
      w_par_nxt   = r_par;
`endif
      if (r_state == S_IDLE) begin
         w_div_nxt = 8'd0;
      end else if (w_bit_end) begin
         w_div_nxt = 8'd0;
      end else begin
         w_div_nxt = r_div + 8'd1;
      end
      case (r_state)
         S_IDLE: begin
            w_idx_nxt = '0;
            if (w_accept) begin
               w_shift_nxt = vote_data;
               w_tx_nxt    = 1'b0;
`ifdef BALLOT_TX_PARITY_EN
               w_par_nxt   = even_parity(vote_data);
`endif
            end else begin
               w_tx_nxt = 1'b1;
            end
         end
         S_START: begin
            if (w_bit_end) begin
               w_tx_nxt    = r_shift[0];
               w_shift_nxt = r_shift >> 1'b1;
            end else begin
               w_tx_nxt = 1'b0;
            end
         end
         S_DATA: begin
            if (w_bit_end && (r_idx == IDX_LAST)) begin
               w_idx_nxt = '0;
`ifdef BALLOT_TX_PARITY_EN
               w_tx_nxt  = r_par;
`else
               w_tx_nxt  = 1'b1;
`endif
            end else if (w_bit_end) begin
               w_idx_nxt   = r_idx + IDX_W'(1);
               w_tx_nxt    = r_shift[0];
               w_shift_nxt = r_shift >> 1'b1;
            end else begin
               w_tx_nxt = r_tx;
            end
         end
`ifdef BALLOT_TX_PARITY_EN
         S_PARITY: begin
            if (w_bit_end) w_tx_nxt = 1'b1;
            else           w_tx_nxt = r_tx;
         end
`endif
         S_STOP: begin
            w_tx_nxt = 1'b1;
            if (w_bit_end) w_count_nxt = r_count + 8'd1;
            else           w_count_nxt = r_count;
         end
         default: begin
            w_tx_nxt = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_ballot_tx.sv
// tb_ballot_tx: randomized bench for ballot_tx with a frame-queue reference model.
// Two instances: CLK_DIV=4 and CLK_DIV=1. Honours BALLOT_TX_PARITY_EN like the design.
module tb_ballot_tx;
   localparam int DW   = 8;
   localparam int DIV0 = 4;
   localparam int DIV1 = 1;
`ifdef BALLOT_TX_PARITY_EN
   localparam int PAR        = 1;
   localparam int NB         = 11;
   localparam int BUSY_CYC   = 44;
   localparam logic [7:0] FRAME_DATA = 8'hA5;
   int exp_bits [NB] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
   localparam int PAR        = 0;
   localparam int NB         = 10;
   localparam int BUSY_CYC   = 40;
   localparam logic [7:0] FRAME_DATA = 8'h01;
   int exp_bits [NB] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] vd0, vd1;
   logic          vv0, vv1;
   logic          rdy0, rdy1, tx0, tx1, bsy0, bsy1;
   logic [7:0]    cnt0, cnt1;
   wire  [1:0]    vv_v  = {vv1, vv0};
   wire  [1:0]    rdy_v = {rdy1, rdy0};
   wire  [1:0]    tx_v  = {tx1, tx0};
   wire  [1:0]    bsy_v = {bsy1, bsy0};

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;
   bit model_q [2][$];
   int model_cnt [2];
   bit log_q [$];
   int n;
   int gap;

   always #5 clk = ~clk;

   ballot_tx #(.DATA_W(DW), .CLK_DIV(DIV0)) u_dut0 (
      .clk(clk), .rst(rst), .vote_data(vd0), .vote_valid(vv0), .vote_ready(rdy0),
      .tx_line(tx0), .busy(bsy0), .sent_count(cnt0));

   ballot_tx #(.DATA_W(DW), .CLK_DIV(DIV1)) u_dut1 (
      .clk(clk), .rst(rst), .vote_data(vd1), .vote_valid(vv1), .vote_ready(rdy1),
      .tx_line(tx1), .busy(bsy1), .sent_count(cnt1));

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_idle(input int m, input int limit);
      int k;
      k = 0;
      while (bsy_v[m] && k < limit) begin
         k++;
         tick();
      end
      chk($sformatf("idle_within_bound[%0d]", m), int'(k < limit), 1);
   endtask

   // Model: an accepted word becomes the list of line levels, one entry per clock cycle.
   function automatic void push_frame(input int m, input logic [DW-1:0] d);
      bit bits [$];
      int div;
      div = (m == 0) ? DIV0 : DIV1;
      bits.push_back(1'b0);
      for (int i = 0; i < DW; i++) bits.push_back(d[i]);
      if (PAR != 0) bits.push_back(^d);
      bits.push_back(1'b1);
      foreach (bits[i]) begin
         for (int k = 0; k < div; k++) model_q[m].push_back(bits[i]);
      end
   endfunction

   // Model update at each rising edge.
   always @(posedge clk) begin
      for (int m = 0; m < 2; m++) begin
         if (rst) begin
            model_q[m].delete();
            model_cnt[m] = 0;
         end else if (model_q[m].size() != 0) begin
            void'(model_q[m].pop_front());
            if (model_q[m].size() == 0) model_cnt[m] = (model_cnt[m] + 1) % 256;
         end else if (vv_v[m]) begin
            push_frame(m, (m == 0) ? vd0 : vd1);
         end
      end
   end

   // Compare DUT outputs against the model mid-cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int m = 0; m < 2; m++) begin
            bit e_busy;
            bit e_tx;
            e_busy = (model_q[m].size() != 0);
            e_tx   = e_busy ? model_q[m][0] : 1'b1;
            chk($sformatf("tx_line[%0d]", m), int'(tx_v[m]), int'(e_tx));
            chk($sformatf("busy[%0d]", m), int'(bsy_v[m]), int'(e_busy));
            chk($sformatf("vote_ready[%0d]", m), int'(rdy_v[m]), int'(!e_busy && !rst));
            chk($sformatf("sent_count[%0d]", m), int'((m == 0) ? cnt0 : cnt1), model_cnt[m]);
         end
      end
   end

   initial begin
      rst = 1'b1; vv0 = 1'b0; vv1 = 1'b0; vd0 = '0; vd1 = '0;
      tick();
      tick();
      chk_en = 1'b1;
      chk("rst_tx", int'(tx0), 1);
      chk("rst_busy", int'(bsy0), 0);
      chk("rst_ready", int'(rdy0), 0);
      chk("rst_count", int'(cnt0), 0);
      rst = 1'b0;
      #1;
      chk("ready_after_release", int'(rdy0), 1);

      // Single frame, literal line sequence sampled one cycle into each bit.
      vd0 = FRAME_DATA; vv0 = 1'b1;
      tick();
      vv0 = 1'b0;
      log_q.delete();
      n = 0;
      while (bsy0 && n < 200) begin
         log_q.push_back(tx0);
         n++;
         tick();
      end
      chk("busy_cycles", log_q.size(), BUSY_CYC);
      chk("start_latency", (log_q.size() > 0) ? int'(log_q[0]) : 2, 0);
      for (int i = 0; i < NB; i++) begin
         chk($sformatf("frame_bit%0d", i), (4 * i + 1 < log_q.size()) ? int'(log_q[4 * i + 1]) : 2, exp_bits[i]);
      end
      chk("frame_count", int'(cnt0), 1);

      // Back-to-back with vote_valid held, CLK_DIV=1.
      rst = 1'b1; tick(); rst = 1'b0;
      vd1 = 8'h0F; vv1 = 1'b1;
      tick();
      vd1 = 8'hF0;
      wait_idle(1, 100);
      gap = 0;
      while (!bsy1 && gap < 10) begin
         gap++;
         tick();
      end
      vv1 = 1'b0;
      chk("b2b_gap", gap, 1);
      wait_idle(1, 100);
      chk("b2b_count", int'(cnt1), 2);

      // Reset in the middle of a frame.
      rst = 1'b1; tick(); rst = 1'b0;
      vd0 = 8'hA5; vv0 = 1'b1;
      tick();
      vv0 = 1'b0;
      repeat (17) tick();
      rst = 1'b1;
      tick();
      chk("abort_tx", int'(tx0), 1);
      chk("abort_count", int'(cnt0), 0);
      chk("abort_busy", int'(bsy0), 0);
      rst = 1'b0;
      #1;
      chk("abort_ready", int'(rdy0), 1);
      repeat (5) tick();
      chk("abort_no_resume", int'(bsy0), 0);

      // vote_valid pulsed mid-frame is ignored.
      vd0 = 8'h5A; vv0 = 1'b1;
      tick();
      vv0 = 1'b0;
      repeat (10) tick();
      vd0 = 8'h33; vv0 = 1'b1;
      tick();
      vv0 = 1'b0;
      wait_idle(0, 100);
      repeat (20) tick();
      chk("ignored_no_extra", int'(bsy0), 0);
      chk("ignored_count", int'(cnt0), 1);

      // Counter wrap over 256 frames.
      rst = 1'b1; tick(); rst = 1'b0;
      for (int f = 1; f <= 256; f++) begin
         vd1 = DW'($urandom); vv1 = 1'b1;
         tick();
         vv1 = 1'b0;
         wait_idle(1, 100);
         if (f == 255) chk("count_255", int'(cnt1), 255);
      end
      chk("count_wrap", int'(cnt1), 0);

      // Random traffic with occasional resets.
      repeat (3000) begin
         vv0 = ($urandom_range(3) == 0);
         vd0 = DW'($urandom);
         vv1 = ($urandom_range(5) == 0);
         vd1 = DW'($urandom);
         rst = ($urandom_range(299) == 0);
         tick();
      end
      rst = 1'b0; vv0 = 1'b0; vv1 = 1'b0;
      repeat (60) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ballot_tx.md
BALLOT_TX -- requirements
Module: ballot_tx

Interface
REQ-001 Parameter DATA_W, default 8: width of one ballot word in bits, legal range 1..16.
REQ-002 Parameter CLK_DIV, default 4: clock cycles per serial bit, legal range 1..255.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port vote_data, input, DATA_W bits: ballot word offered by the MCU.
REQ-006 Port vote_valid, input, 1 bit: vote_data is valid and offered for transmission.
REQ-007 Port vote_ready, output, 1 bit: block can accept a ballot this cycle.
REQ-008 Port tx_line, output, 1 bit: serial line to the voter; idles high.
REQ-009 Port busy, output, 1 bit: high whenever a frame is being sent.
REQ-010 Port sent_count, output, 8 bits: number of fully sent frames, modulo 256.

Function
REQ-011 States SHALL be IDLE, START, DATA, PARITY, STOP; exactly one state is active at a time.
REQ-012 vote_ready SHALL be 1 only in IDLE with rst low; busy SHALL be the inverse of IDLE.
REQ-013 Acceptance occurs on a cycle with vote_valid=1 and vote_ready=1: vote_data is latched into a shift register and the state moves to START.
REQ-014 vote_valid while vote_ready=0 SHALL be ignored: no latching, no queuing, and no effect on the frame in flight.
REQ-015 tx_line SHALL go low on the cycle after acceptance (latency 1) and is driven from a register, never combinationally from inputs.
REQ-016 Every bit, including start, parity and stop, SHALL last exactly CLK_DIV cycles, timed by a divider counter reloaded at each bit boundary.
REQ-017 In DATA, DATA_W bits SHALL be sent LSB first; the bit index wraps from DATA_W-1 into PARITY, or into STOP when there is no parity bit.
REQ-018 The PARITY bit SHALL be the XOR of all DATA_W latched bits (even parity).
REQ-019 STOP SHALL drive tx_line=1 for CLK_DIV cycles, then return to IDLE; sent_count increments on that same edge.
REQ-020 sent_count SHALL wrap from 255 to 0 with no flag.
REQ-021 Back-to-back: vote_ready is 1 on the first IDLE cycle after STOP, so a held vote_valid starts the next frame with exactly one idle-high cycle between stop and start.
REQ-022 With CLK_DIV=1, each bit SHALL last exactly one cycle.
REQ-023 Total frame length SHALL be (DATA_W+3)*CLK_DIV cycles with parity and (DATA_W+2)*CLK_DIV without.

Reset
REQ-024 While rst=1: state IDLE, tx_line=1, busy=0, vote_ready=0, sent_count=0, divider and bit index 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame on the next edge (tx_line=1); the aborted frame SHALL NOT count, and no partial bits SHALL be sent after reset releases.
REQ-026 vote_ready SHALL be 1 on the first cycle after rst deasserts.

Configuration
REQ-027 Macro BALLOT_TX_PARITY_EN: when defined, the PARITY state and bit are compiled in per REQ-018; when undefined, PARITY is absent, DATA goes directly to STOP, and no parity logic exists.

Verification
REQ-028 Reset, CLK_DIV=4, parity on, send 0xA5 -> tx_line sequence 0,1,0,1,0,0,1,0,1,0,1 (each bit 4 cycles); sent_count=1; 44 busy cycles.
REQ-029 Same with parity off, send 0x01 -> 0,1,0,0,0,0,0,0,0,1; 40 busy cycles; sent_count=1.
REQ-030 vote_valid held high with 0x0F then 0xF0, CLK_DIV=1 -> two frames separated by exactly one idle-high cycle; second vote_data latched only at the second acceptance.
REQ-031 Reset pulsed during bit 3 of a frame -> tx_line=1 on the next edge, sent_count=0, vote_ready=1 one cycle after release.
REQ-032 Send 256 frames -> sent_count reads 0 after the last STOP; after frame 255 it reads 255.
REQ-033 vote_valid pulsed mid-frame with 0x33 -> ignored; the in-flight frame is unchanged and no extra frame is sent.
